// File: rtl/ripple_carry_adder_rca_4bit_pkg.sv
// Shared constants for the registered ripple-carry adder.
// Holds the default operand width and the largest width the adder supports.
package ripple_carry_adder_rca_4bit_pkg;

   localparam int DEFAULT_WIDTH = 4;
   localparam int MAX_WIDTH     = 32;

endpackage

// File: rtl/ripple_carry_adder_rca_4bit_full_adder.sv
// One-bit combinational full adder.
// The top level chains WIDTH of these to form the carry ripple.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic half_sum;

   assign half_sum = a ^ b;
   assign s        = half_sum ^ cin;
   assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/ripple_carry_adder_rca_4bit.sv
// Registered ripple-carry adder computing A + B + C_in.
// Sum and carry-out appear from registers one clock after the operands are sampled.
module ripple_carry_adder_rca_4bit
   import ripple_carry_adder_rca_4bit_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_in,
   input  logic             in_valid,
   output logic [WIDTH-1:0] S,
   output logic             C_out,
   output logic             out_valid
);

   generate
      if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
         $error("ripple_carry_adder_rca_4bit: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
      end
   endgenerate

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_comb;

   assign carry[0] = C_in;

   // Carry ripples bit-serially through one full adder per bit.
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_stage
         full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry[i]),
            .s    (sum_comb[i]),
            .cout (carry[i+1])
         );
      end
   endgenerate

   // Results load only on valid input; out_valid tracks whether this cycle's input was valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         S         <= '0;
         C_out     <= 1'b0;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         S         <= sum_comb;
         C_out     <= carry[WIDTH];
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ripple_carry_adder_rca_4bit.sv
// Self-checking bench for the registered 4-bit ripple-carry adder.
// Directed, exhaustive and random operands are compared against an arithmetic reference model.
module tb_ripple_carry_adder_rca_4bit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] A;
   logic [3:0] B;
   logic       C_in;
   logic       in_valid;
   logic [3:0] S;
   logic       C_out;
   logic       out_valid;

   int checks   = 0;
   int failures = 0;

   logic [3:0] exp_s;
   logic       exp_c;
   logic       exp_v;

   always #5 clk = ~clk;

   ripple_carry_adder_rca_4bit #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .A         (A),
      .B         (B),
      .C_in      (C_in),
      .in_valid  (in_valid),
      .S         (S),
      .C_out     (C_out),
      .out_valid (out_valid)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, advance the reference model at the edge, then compare.
   task automatic applyStimulus(input int a, input int b, input int cin,
                                input logic valid, input logic rstn, input string tag);
      int total;
      @(negedge clk);
      A        = 4'(a);
      B        = 4'(b);
      C_in     = cin[0];
      in_valid = valid;
      rst_n    = rstn;
      @(posedge clk);
      total = (a % 16) + (b % 16) + (cin % 2);
      if (!rstn) begin
         exp_s = 4'd0;
         exp_c = 1'b0;
         exp_v = 1'b0;
      end else if (valid) begin
         exp_s = 4'(total % 16);
         exp_c = (total >= 16);
         exp_v = 1'b1;
      end else begin
         exp_v = 1'b0;
      end
      #1;
      checkOutput({tag, ".sum"},   32'(S),         32'(exp_s));
      checkOutput({tag, ".cout"},  32'(C_out),     32'(exp_c));
      checkOutput({tag, ".valid"}, 32'(out_valid), 32'(exp_v));
   endtask

   initial begin
      int da[8];
      int db[8];
      int dc[8];
      int ra;
      int rb;
      int rc;
      da = '{3, 3, 0, 12, 13, 8, 15, 15};
      db = '{10, 11, 0, 10, 10, 8, 15, 0};
      dc = '{1, 0, 0, 1, 1, 1, 1, 1};

      rst_n    = 1'b0;
      A        = '0;
      B        = '0;
      C_in     = 1'b0;
      in_valid = 1'b0;

      // Reset must dominate a valid all-ones input.
      for (int i = 0; i < 3; i++) applyStimulus(15, 15, 1, 1'b1, 1'b0, "reset");

      for (int i = 0; i < 8; i++) applyStimulus(da[i], db[i], dc[i], 1'b1, 1'b1, "directed");

      applyStimulus(3, 10, 1, 1'b1, 1'b1, "hold_load");
      for (int i = 0; i < 3; i++) applyStimulus(i + 5, 9 - i, i % 2, 1'b0, 1'b1, "hold");

      for (int n = 0; n < 512; n++) begin
         if (n == 256) applyStimulus(15, 15, 1, 1'b1, 1'b0, "sweep_reset");
         applyStimulus(n / 32, (n / 2) % 16, n % 2, 1'b1, 1'b1, "sweep");
      end

      for (int i = 0; i < 200; i++) begin
         ra = int'($urandom_range(15, 0));
         rb = int'($urandom_range(15, 0));
         rc = int'($urandom_range(1, 0));
         applyStimulus(ra, rb, rc, ($urandom_range(3, 0) != 0), ($urandom_range(31, 0) != 0), "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
